port_arbiter: RTL
=================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter REQ_WIDTH, default 2, sets the requester index width; requester count N = 2**REQ_WIDTH.
REQ-002 Parameter BEAT_WIDTH, default 3, sets the beat counter width; MAX_BEATS = 2**BEAT_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req  input  N  per-requester access request, level, held for the whole burst.
REQ-006 req_last  input  N  per-requester last-beat marker, sampled only for the granted requester.
REQ-007 port_ready  input  1  shared cache port accepts a beat this cycle.
REQ-008 grant_valid  output  1  a requester owns the port.
REQ-009 grant_idx  output  REQ_WIDTH  binary index of the owner; 0 when grant_valid=0.
REQ-010 grant_onehot  output  N  one-hot decode of grant_idx when grant_valid=1, else all zero.
REQ-011 beat  output  1  combinational: grant_valid & port_ready & req[grant_idx].
REQ-012 beat_cnt  output  BEAT_WIDTH  beats completed in the current burst.
REQ-013 release  output  1  one-cycle registered pulse on the cycle after the grant ends.
REQ-014 abort  output  1  one-cycle registered pulse; grant ended by request drop or beat overrun.

Function
REQ-015 Two states, IDLE and BUSY; all outputs except beat are registered.
REQ-016 IDLE, req!=0: next cycle BUSY, grant_valid=1, grant_idx = first asserted req at or after rr_ptr, searching upward modulo N.
REQ-017 IDLE, req=0: stay IDLE; all outputs 0.
REQ-018 Grant latency: exactly one cycle from req assertion (port idle) to grant_valid.
REQ-019 BUSY: each beat increments beat_cnt by 1; no increment without beat.
REQ-020 BUSY, beat & req_last[grant_idx]: next cycle IDLE, grant_valid=0, beat_cnt=0, release=1, abort=0.
REQ-021 BUSY, req[grant_idx]=0 (not last-beat release): next cycle IDLE, release=1, abort=1; beat not asserted that cycle.
REQ-022 BUSY, beat without last while beat_cnt=MAX_BEATS-1 (overrun): next cycle IDLE, release=1, abort=1.
REQ-023 On every grant end, rr_ptr = grant_idx+1 modulo N (wraps N-1 -> 0).
REQ-024 At least one IDLE cycle between consecutive grants; no back-to-back ownership transfer.
REQ-025 Changes on req of non-owners while BUSY are ignored; grant_idx never changes within BUSY.
REQ-026 Simultaneous last-beat and req drop of owner cannot occur (beat requires req); last-beat at beat_cnt=MAX_BEATS-1 is a normal release, abort=0.
REQ-027 port_ready low while BUSY: hold state, beat_cnt unchanged, no timeout.
REQ-028 release and abort high for exactly one cycle per grant end, never otherwise.

Reset
REQ-029 rst_n=0 at a rising edge: state IDLE, rr_ptr=0, grant_valid=0, grant_idx=0, grant_onehot=0, beat_cnt=0, release=0, abort=0.
REQ-030 Reset mid-burst: grant dropped next edge without release or abort pulse; arbitration restarts from index 0.
REQ-031 Reset has priority over all other inputs in the same cycle.

Verification (N=4, BEAT_WIDTH=3)
REQ-032 Reset, then req=4'b0110, port_ready=1 -> cycle+1 grant_idx=1, grant_onehot=4'b0010.
REQ-033 Requester 1 sends 3 beats, req_last[1] on third -> beat_cnt 0,1,2; next cycle release=1, abort=0, IDLE; next grant goes to 2.
REQ-034 Owner 3 completes, req=4'b1001 -> after idle cycle grant_idx=0 (wrap), not 3.
REQ-035 Owner drops req after 2 beats, no last -> next cycle release=1, abort=1, beat_cnt=0.
REQ-036 Owner sends 8 beats, no last -> after eighth beat release=1, abort=1; port_ready held low 5 cycles mid-burst leaves beat_cnt unchanged.
REQ-037 rst_n=0 while BUSY, beat_cnt=4 -> next cycle all outputs 0, release=0, abort=0; req=4'b1111 then grants index 0.

Source files
------------

// File: rtl/port_arbiter.sv
// Round-robin arbiter granting a shared cache port to one requester for a whole burst.
// A grant ends on a last beat, on a request drop by the owner, or on a beat-count overrun.
module port_arbiter #(
    parameter int unsigned REQ_WIDTH  = 2,
    parameter int unsigned BEAT_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [(2**REQ_WIDTH)-1:0]   req,
    input  logic [(2**REQ_WIDTH)-1:0]   req_last,
    input  logic                        port_ready,
    output logic                        grant_valid,
    output logic [REQ_WIDTH-1:0]        grant_idx,
    output logic [(2**REQ_WIDTH)-1:0]   grant_onehot,
    output logic                        beat,
    output logic [BEAT_WIDTH-1:0]       beat_cnt,
    output logic                        release_pulse,
    output logic                        abort
);

    localparam int unsigned N = 2**REQ_WIDTH;

    typedef enum logic {StIdle, StBusy} state_t;

    state_t               state;
    logic [REQ_WIDTH-1:0] rr_ptr;
    logic [REQ_WIDTH-1:0] pick;
    logic [REQ_WIDTH-1:0] idx;
    logic                 found;
    logic                 grant_end;
    logic                 end_abort;

    assign beat = grant_valid & port_ready & req[grant_idx];

    // First asserted request at or after rr_ptr, wrapping modulo N.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = rr_ptr + REQ_WIDTH'(i);
            if (req[idx] && !found) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        grant_end = 1'b0;
        end_abort = 1'b0;
        if (state == StBusy) begin
            if (!req[grant_idx]) begin
                grant_end = 1'b1;
                end_abort = 1'b1;
            end else if (beat) begin
                if (req_last[grant_idx]) begin
                    grant_end = 1'b1;
                end else if (&beat_cnt) begin
                    grant_end = 1'b1;
                    end_abort = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= StIdle;
            rr_ptr        <= '0;
            grant_valid   <= 1'b0;
            grant_idx     <= '0;
            grant_onehot  <= '0;
            beat_cnt      <= '0;
            release_pulse <= 1'b0;
            abort         <= 1'b0;
        end else begin
            release_pulse <= 1'b0;
            abort         <= 1'b0;
            case (state)
                StIdle: begin
                    if (found) begin
                        state        <= StBusy;
                        grant_valid  <= 1'b1;
                        grant_idx    <= pick;
                        grant_onehot <= N'(1) << pick;
                        beat_cnt     <= '0;
                    end
                end
                StBusy: begin
                    if (grant_end) begin
                        state         <= StIdle;
                        rr_ptr        <= grant_idx + REQ_WIDTH'(1);
                        grant_valid   <= 1'b0;
                        grant_idx     <= '0;
                        grant_onehot  <= '0;
                        beat_cnt      <= '0;
                        release_pulse <= 1'b1;
                        abort         <= end_abort;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
